// File: rtl/poc_pkg.sv
// Shared definitions for the POC parallel printer link: state encoding,
// line-control byte values and the default per-byte print time.
package poc_pkg;

    typedef enum logic [1:0] {
        ST_READY   = 2'b00,
        ST_PRINT   = 2'b01,
        ST_NOPAPER = 2'b10
    } state_e;

    localparam int PRINT_CYCLES_DEFAULT = 8;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    function automatic logic is_line_end(input logic [7:0] b);
        return (b == ASCII_LF) || (b == ASCII_CR);
    endfunction

endpackage

// File: rtl/print_timer.sv
// Per-byte print timer: loads to zero, counts up to PRINT_CYCLES-1 and then
// saturates there; o_tc flags the terminal count.
module print_timer
    import poc_pkg::*;
#(
    parameter int PRINT_CYCLES = PRINT_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_hold,
    output logic o_tc
);

    localparam int CW = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(PRINT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins, then hold, then saturate at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = {CW{1'b0}};
        end else if (i_hold) begin
            cnt_d = cnt_q;
        end else if (cnt_q == TC_VAL) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/printer_rx.sv
// Printer-side end of the POC parallel link: accepts a byte per i_tr strobe,
// holds o_rdy low while printing, and tracks column, wrap and character count.
module printer_rx
    import poc_pkg::*;
#(
    parameter int PRINT_CYCLES = PRINT_CYCLES_DEFAULT,
    parameter int LINE_WIDTH   = 16,
    parameter int CNT_W        = 16,
    localparam int COL_W       = $clog2(LINE_WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tr,
    input  logic [7:0]       i_pd,
    output logic             o_rdy,
    input  logic             i_paper_ok,
    output logic             o_char_valid,
    output logic [7:0]       o_char,
    output logic [COL_W-1:0] o_col,
    output logic             o_line_wrap,
    output logic [CNT_W-1:0] o_char_count,
    output logic             o_overrun
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);

    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             rdy_q, rdy_d;
    logic             cv_q, cv_d;
    logic [7:0]       char_q, char_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;

    logic             accept_s;
    logic             done_s;
    logic             tc_s;

    assign accept_s = (state_q == ST_READY) && i_tr;

    print_timer #(
        .PRINT_CYCLES (PRINT_CYCLES)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (accept_s),
        .i_hold  (state_q != ST_PRINT),
        .o_tc    (tc_s)
    );

    // State transitions; a transfer request in READY wins over missing paper.
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        done_s  = 1'b0;
        case (state_q)
            ST_READY: begin
                if (i_tr) begin
                    state_d = ST_PRINT;
                    byte_d  = i_pd;
                end else if (!i_paper_ok) begin
                    state_d = ST_NOPAPER;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_PRINT: begin
                if (tc_s && i_paper_ok) begin
                    state_d = ST_READY;
                    done_s  = 1'b1;
                end else begin
                    state_d = ST_PRINT;
                end
            end
            ST_NOPAPER: begin
                if (i_paper_ok) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_NOPAPER;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Output next-values: everything is computed one cycle ahead and registered.
    always_comb begin
        rdy_d  = (state_d == ST_READY);
        cv_d   = done_s;
        char_d = char_q;
        col_d  = col_q;
        wrap_d = 1'b0;
        cnt_d  = cnt_q;
        ovr_d  = ovr_q | (i_tr && (state_q != ST_READY));
        if (done_s) begin
            char_d = byte_q;
            cnt_d  = cnt_q + CNT_W'(1);
            if (is_line_end(byte_q)) begin
                col_d = {COL_W{1'b0}};
            end else if (col_q == COL_LAST) begin
                col_d  = {COL_W{1'b0}};
                wrap_d = 1'b1;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else begin
            char_d = char_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_READY;
            byte_q  <= 8'h00;
            rdy_q   <= 1'b1;
            cv_q    <= 1'b0;
            char_q  <= 8'h00;
            col_q   <= {COL_W{1'b0}};
            wrap_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            rdy_q   <= rdy_d;
            cv_q    <= cv_d;
            char_q  <= char_d;
            col_q   <= col_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_rdy        = rdy_q;
    assign o_char_valid = cv_q;
    assign o_char       = char_q;
    assign o_col        = col_q;
    assign o_line_wrap  = wrap_q;
    assign o_char_count = cnt_q;
    assign o_overrun    = ovr_q;

endmodule

// File: doc/printer_rx.md
Name: printer_rx

Overview:
- Printer-side end of the POC parallel printer link.
- Accepts one byte per transfer-request strobe (i_tr with i_pd) and drops o_rdy while the byte is "printed" for a fixed number of cycles.
- Raises o_rdy again when printing ends. That rising edge is what the POC uses to mark a transfer complete.
- Also tracks the print column, the line wrap and the total character count. It is used as the printer model in system benches and as the printer front end in hardware.

Parameters:
- PRINT_CYCLES, 8, cycles spent in PRINT per byte; must be at least 1.
- LINE_WIDTH, 16, number of columns per line; must be at least 2.
- CNT_W, 16, width of the total character counter.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- i_tr  in  1  transfer request from the POC; one-cycle pulse; i_pd is valid in the same cycle.
- i_pd  in  8  printer data byte from the POC.
- o_rdy  out  1  printer ready (registered); 1 = can accept a byte.
- i_paper_ok  in  1  paper present; 0 stalls printing.
- o_char_valid  out  1  one-cycle pulse; o_char holds the byte that was just printed.
- o_char  out  8  last printed byte.
- o_col  out  log2(LINE_WIDTH)  current print column.
- o_line_wrap  out  1  one-cycle pulse when the column wraps because the line is full.
- o_char_count  out  CNT_W  total bytes printed; wraps modulo 2^CNT_W.
- o_overrun  out  1  sticky; set when i_tr arrives while not in READY.

Behaviour:
- All outputs are registered. Reset is taken on the i_clk edge while i_rst_n = 0.
- Reset values:
  - state = READY, o_rdy = 1.
  - o_char_valid = 0, o_char = 0, o_col = 0, o_line_wrap = 0, o_char_count = 0, o_overrun = 0.
  - Print counter = 0.
- Reset asserted mid-print discards the captured byte: no o_char_valid, and the count is unchanged.
- State READY (o_rdy = 1):
  - i_tr = 1: capture i_pd, clear the counter, go to PRINT, o_rdy = 0 on the next cycle.
  - i_tr is accepted regardless of i_paper_ok, because o_rdy was already 1 and visible to the POC.
  - i_tr = 0 and i_paper_ok = 0: go to NOPAPER, o_rdy = 0 on the next cycle.
- State NOPAPER (o_rdy = 0):
  - Go to READY when i_paper_ok = 1; o_rdy = 1 on the next cycle.
- State PRINT (o_rdy = 0):
  - The counter increments each cycle until it reaches PRINT_CYCLES-1.
  - At counter = PRINT_CYCLES-1 with i_paper_ok = 1: go to READY. On the next cycle o_rdy = 1, o_char_valid = 1, o_char = the captured byte, and o_char_count increments.
  - At counter = PRINT_CYCLES-1 with i_paper_ok = 0: the counter holds and the state stays PRINT until paper returns, then completes as above.
- Timing: i_tr in cycle T gives o_rdy = 0 for cycles T+1 .. T+PRINT_CYCLES, and o_rdy = 1 plus the o_char_valid pulse in cycle T+PRINT_CYCLES+1.
- The next i_tr is accepted in that same cycle (back-to-back).
- Column update, on each printed byte:
  - Byte 0x0A or 0x0D: o_col = 0, no wrap pulse.
  - Otherwise, if o_col = LINE_WIDTH-1: o_col = 0 and o_line_wrap pulses together with o_char_valid.
  - Otherwise: o_col + 1.
- o_char_count counts every printed byte, control bytes included, and wraps from all-ones to 0.
- Overrun:
  - i_tr in PRINT or NOPAPER sets o_overrun. The byte is ignored and the print in progress is unaffected.
  - o_overrun is cleared only by reset.
- Undefined state encodings go to READY on the next cycle.

Decomposition:
- Shared package poc_pkg holds:
  - The state encoding: READY, PRINT, NOPAPER.
  - Constants ASCII_LF = 8'h0A and ASCII_CR = 8'h0D.
  - The default PRINT_CYCLES value, so POC benches and this block agree.
- Sub-module print_timer: a loadable counter with a hold input and a terminal-count output, parameterised by PRINT_CYCLES.
- The column and character counters stay inline.

Test Plan:
- Reset, then i_pd = 8'h41 with a one-cycle i_tr at cycle 0 (PRINT_CYCLES = 8) -> o_rdy low for cycles 1-8. In cycle 9: o_rdy = 1, o_char_valid = 1, o_char = 8'h41, o_col = 1, o_char_count = 1.
- 16 back-to-back bytes 8'h30, each i_tr issued the cycle o_rdy rises -> the 16th emit gives o_col = 0 with an o_line_wrap pulse. Count = 16. No overrun.
- Bytes 8'h41, 8'h42, 8'h0A -> o_col goes 1, 2, 0. No o_line_wrap. Count = 3.
- i_paper_ok = 0 from cycle 4 after i_tr at cycle 0, restored at cycle 20 -> PRINT holds at terminal count and o_rdy stays 0. o_rdy = 1 and o_char_valid in cycle 21.
- i_tr at cycle 0, second i_tr at cycle 3 with i_pd = 8'hFF -> o_overrun = 1 from cycle 4. The first byte is still printed at cycle 9 and 8'hFF is never emitted.
- i_rst_n low at cycle 4 during PRINT -> the next cycle shows o_rdy = 1, count = 0 and o_col = 0, with no o_char_valid pulse.
